// File: rtl/conv1_pkg.sv
// Shared types and geometry for the conv1 stage: pixel/window types and
// the raster position constants used by the window generator.
package conv1_pkg;

   localparam int IMG_W  = 28;
   localparam int IMG_H  = 28;
   localparam int DATA_W = 16;
   localparam int K      = 3;
   localparam int WIN_W  = K * K * DATA_W;

   // Position counters are 5 bits, enough for 0..27 in either axis.
   localparam int POS_W = 5;

   typedef logic [DATA_W-1:0] pix_t;
   typedef pix_t [K*K-1:0]    win_t;
   typedef logic [POS_W-1:0]  pos_t;

   localparam pos_t COL_MAX   = pos_t'(IMG_W - 1);
   localparam pos_t ROW_MAX   = pos_t'(IMG_H - 1);
   localparam pos_t WIN_START = pos_t'(K - 1);

   // Flattened window index: row 0 is the oldest (top) row, column 0 the leftmost.
   function automatic int win_idx(input int r, input int c);
      return r * K + c;
   endfunction

endpackage

// File: rtl/conv1_window_if.sv
// Pixel-in / window-out valid-ready bundle of the conv1 window generator.
interface conv1_window_if;
   import conv1_pkg::*;

   logic in_valid;
   logic in_ready;
   pix_t in_data;
   logic out_valid;
   logic out_ready;
   win_t out_win;
   logic out_last;

   // Block side.
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_win, out_last
   );

   // Environment side: pixel source and window sink.
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_win, out_last
   );

endinterface

// File: rtl/conv1_line_buffer.sv
// One image row of pixel storage: same-index read and write each cycle,
// the read returning the value held before this cycle's write.
module conv1_line_buffer #(
   parameter  int DEPTH  = 28,
   parameter  int WIDTH  = 16,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WIDTH-1:0]  wdata,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Asynchronous read of the old entry gives read-before-write for free.
   assign rdata = mem[addr];

   // NOTE: storage arrays take no reset; clearing them would forbid RAM
   // mapping, and stale rows are never observable at the output.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

endmodule

// File: rtl/conv1_window.sv
// 3x3 sliding-window generator: buffers two rows and emits one window per
// accepted pixel whose full neighbourhood lies inside the image.
module conv1_window
   import conv1_pkg::*;
(
   input  logic          clk,
   input  logic          reset_n,
   conv1_window_if.slave bus
);

   pos_t col;
   pos_t row;
   logic accept;
   logic emit;
   logic last_pix;
   pix_t lb0_rd;
   pix_t lb1_rd;
   win_t win_q;
   win_t win_next;
   win_t out_win_q;
   logic out_valid_q;
   logic out_last_q;

   // No skid buffer: a pixel can enter only if the output slot is free or draining.
   assign bus.in_ready  = !out_valid_q || bus.out_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_win   = out_win_q;
   assign bus.out_last  = out_last_q;

   assign accept   = bus.in_valid && bus.in_ready;
   assign last_pix = (row == ROW_MAX) && (col == COL_MAX);
   assign emit     = accept && (row >= WIN_START) && (col >= WIN_START);

   // LB1 holds the previous row; on each accept it cascades into LB0.
   conv1_line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb0 (
      .clk   (clk),
      .we    (accept),
      .addr  (col),
      .wdata (lb1_rd),
      .rdata (lb0_rd)
   );

   conv1_line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb1 (
      .clk   (clk),
      .we    (accept),
      .addr  (col),
      .wdata (bus.in_data),
      .rdata (lb1_rd)
   );

   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      win_next = win_q;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K - 1; c++) begin
            win_next[win_idx(r, c)] = win_q[win_idx(r, c + 1)];
         end
      end
      win_next[win_idx(0, K - 1)] = lb0_rd;
      win_next[win_idx(1, K - 1)] = lb1_rd;
      win_next[win_idx(2, K - 1)] = bus.in_data;
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         col <= '0;
         row <= '0;
      end else if (accept) begin
         if (col == COL_MAX) begin
            col <= '0;
            row <= (row == ROW_MAX) ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   // A window-producing accept overrides the drain, so back-to-back windows
   // flow with no bubble while out_ready stays high.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         win_q       <= '0;
         out_win_q   <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         if (accept) begin
            win_q <= win_next;
         end
         if (emit) begin
            out_win_q   <= win_next;
            out_last_q  <= last_pix;
            out_valid_q <= 1'b1;
         end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_conv1_window.sv
// Self-checking bench for conv1_window: directed streams plus randomized
// handshakes, scored against an image-array model of the 3x3 windows.
module tb_conv1_window;
   import conv1_pkg::*;

   localparam int CYC_LIMIT = 60000;

   logic clk = 1'b0;
   logic reset_n;
   conv1_window_if bus ();

   conv1_window dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cycles = 0;

   // Reference model: the current frame as a 2-D image plus one output slot.
   int               img [IMG_H][IMG_W];
   int               prow;
   int               pcol;
   logic             exp_valid;
   logic             exp_last;
   logic [WIN_W-1:0] exp_win;

   logic [WIN_W-1:0] fired_win [$];
   bit               fired_last [$];

   task automatic check(input string tag, input logic [WIN_W-1:0] obs, input logic [WIN_W-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Window whose top-left pixel carries value tl in a row*28+col ramp image.
   function automatic logic [WIN_W-1:0] ramp_win(input int tl);
      logic [WIN_W-1:0] w;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            w[(r*3 + c)*DATA_W +: DATA_W] = DATA_W'(tl + r*IMG_W + c);
      return w;
   endfunction

   task automatic model_clear();
      prow      = 0;
      pcol      = 0;
      exp_valid = 1'b0;
      exp_last  = 1'b0;
      exp_win   = '0;
   endtask

   task automatic model_accept(input pix_t d);
      img[prow][pcol] = int'(d);
      if (prow >= 2 && pcol >= 2) begin
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               exp_win[(r*3 + c)*DATA_W +: DATA_W] = DATA_W'(img[prow-2+r][pcol-2+c]);
         exp_last  = (prow == IMG_H-1) && (pcol == IMG_W-1);
         exp_valid = 1'b1;
      end
      pcol++;
      if (pcol == IMG_W) begin
         pcol = 0;
         prow = (prow == IMG_H-1) ? 0 : prow + 1;
      end
   endtask

   // One clock: drive, compare against the model, advance the edge, update the model.
   task automatic cycle(input logic v, input pix_t d, input logic rdy, output bit acc);
      logic exp_rdy;
      bit   fire;
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.out_ready = rdy;
      #1;
      exp_rdy = !exp_valid || rdy;
      check("in_ready", bus.in_ready, exp_rdy);
      check("out_valid", bus.out_valid, exp_valid);
      if (exp_valid) begin
         check("out_win", bus.out_win, exp_win);
         check("out_last", bus.out_last, exp_last);
      end
      acc  = v && exp_rdy;
      fire = exp_valid && rdy;
      if (fire) begin
         fired_win.push_back(bus.out_win);
         fired_last.push_back(bus.out_last);
      end
      @(posedge clk);
      #1;
      cycles++;
      if (fire) exp_valid = 1'b0;
      if (acc) model_accept(d);
   endtask

   task automatic do_reset();
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      reset_n       = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      model_clear();
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_out_last", bus.out_last, 1'b0);
      check("rst_out_win", bus.out_win, '0);
      check("rst_in_ready", bus.in_ready, 1'b1);
   endtask

   // Feed n pixels; bp_at >= 0 stalls the sink for 10 cycles once that many windows have left.
   task automatic run_pixels(input int base, input int n, input int pv, input int pr,
                             input bit rnd, input int bp_at);
      int               done = 0;
      int               hold = 0;
      bit               bp_done = 1'b0;
      bit               acc;
      logic             v;
      logic             rdy;
      pix_t             d;
      logic [WIN_W-1:0] held = '0;
      while (done < n) begin
         if (cycles > CYC_LIMIT) begin
            check("cycle_budget", done, n);
            break;
         end
         v   = ($urandom_range(99) < pv);
         rdy = ($urandom_range(99) < pr);
         if (bp_at >= 0 && !bp_done && exp_valid && fired_win.size() == bp_at) begin
            hold    = 10;
            bp_done = 1'b1;
            held    = exp_win;
         end
         if (hold > 0) begin
            v   = 1'b1;
            rdy = 1'b0;
         end
         d = rnd ? pix_t'($urandom) : pix_t'(base + prow*IMG_W + pcol);
         cycle(v, d, rdy, acc);
         if (hold > 0) begin
            check("bp_in_ready", bus.in_ready, 1'b0);
            check("bp_out_win", bus.out_win, held);
            check("bp_out_last", bus.out_last, 1'b0);
            hold--;
         end
         if (acc) done++;
      end
   endtask

   task automatic drain();
      bit acc;
      for (int i = 0; i < 4 && exp_valid; i++) cycle(1'b0, '0, 1'b1, acc);
   endtask

   task automatic clear_fired();
      fired_win.delete();
      fired_last.delete();
   endtask

   function automatic int count_last();
      int n = 0;
      foreach (fired_last[i]) n += int'(fired_last[i]);
      return n;
   endfunction

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      reset_n       = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      // Streaming ramp frame at full rate.
      clear_fired();
      run_pixels(0, IMG_W*IMG_H, 100, 100, 1'b0, -1);
      drain();
      check("stream_count", fired_win.size(), 676);
      check("stream_first_win", fired_win[0], ramp_win(0));
      check("stream_first_last", fired_last[0], 1'b0);
      check("stream_final_win", fired_win[675], ramp_win(25*IMG_W + 25));
      check("stream_final_last", fired_last[675], 1'b1);
      check("stream_last_count", count_last(), 1);

      // Sink stalls for 10 cycles while window 5 is presented.
      clear_fired();
      run_pixels(0, IMG_W*IMG_H, 100, 100, 1'b0, 5);
      drain();
      check("bp_count", fired_win.size(), 676);
      check("bp_win5", fired_win[5], ramp_win(5));
      check("bp_win6", fired_win[6], ramp_win(6));

      // Two frames back to back, second offset by 1000.
      clear_fired();
      run_pixels(0, IMG_W*IMG_H, 100, 100, 1'b0, -1);
      run_pixels(1000, IMG_W*IMG_H, 100, 100, 1'b0, -1);
      drain();
      check("b2b_count", fired_win.size(), 1352);
      check("b2b_f1_last", fired_last[675], 1'b1);
      check("b2b_f2_first", fired_win[676], ramp_win(1000));
      check("b2b_f2_final", fired_win[1351], ramp_win(1000 + 25*IMG_W + 25));
      check("b2b_last_count", count_last(), 2);

      // Reset after 300 pixels aborts the frame.
      clear_fired();
      run_pixels(0, 300, 100, 100, 1'b0, -1);
      do_reset();
      clear_fired();
      run_pixels(0, IMG_W*IMG_H, 100, 100, 1'b0, -1);
      drain();
      check("mrst_count", fired_win.size(), 676);
      check("mrst_first_win", fired_win[0], ramp_win(0));

      // Random data with 50% valid / 50% ready over two frames.
      clear_fired();
      run_pixels(0, 2*IMG_W*IMG_H, 50, 50, 1'b1, -1);
      drain();
      check("rand_count", fired_win.size(), 1352);
      check("rand_last_count", count_last(), 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
